load_store_unit: RTL and testbench
==================================

# load_store_unit

Pipeline-side initiator for data memory accesses: accepts one load/store request at a time from the execute stage, checks alignment and mode, and drives a word-wide memory port with byte enables and lane-shifted write data. It waits for the memory acknowledge, extracts and sign/zero-extends load data, and returns a single-cycle completion with error flags. It sits between the core's memory stage and the data memory/cache; all lane steering and extension happens here, so the memory side stays a plain byte-enabled word RAM.

## Interface

- TIMEOUT_CYCLES, 16, maximum cycles `o_MemRequest` stays high without `i_MemAck` before abort (range 1..255)
- i_Clock  in  1  clock, rising edge
- i_Reset_n  in  1  asynchronous active-low reset
- i_Valid  in  1  request valid from pipeline
- o_Ready  out  1  unit idle, can accept request
- i_Write  in  1  1 = store, 0 = load
- i_Mode  in  3  RV32 funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU loads only)
- i_Address  in  32  byte address
- i_StoreData  in  32  store data, right-aligned
- o_Done  out  1  one-cycle completion pulse
- o_LoadData  out  32  extended load result, valid with `o_Done`
- o_MisalignedAccess  out  1  error flag, valid with `o_Done`
- o_BadInstruction  out  1  illegal mode flag, valid with `o_Done`
- o_BusError  out  1  timeout flag, valid with `o_Done`
- o_MemRequest  out  1  memory request, held until ack
- o_MemWrite  out  1  1 = write
- o_MemAddress  out  32  word address, bits [1:0] = 00
- o_MemByteEnable  out  4  byte lanes; 0000 for reads
- o_MemWriteData  out  32  lane-shifted write data
- i_MemAck  in  1  memory accepted write / read data valid this cycle
- i_MemReadData  in  32  read word, sampled when `i_MemAck` is high

## Operation

- States: IDLE, REQUEST, RESPOND. Reset → IDLE.
- IDLE: `o_Ready`=1. On `i_Valid`, latch request, then decode:
  - Illegal mode (011, 110, 111 any; 100/101 with `i_Write`=1) → RESPOND, `o_BadInstruction`=1.
  - Misaligned (H/HU with addr[0]=1; W with addr[1:0]≠00) → RESPOND, `o_MisalignedAccess`=1. Bad mode takes priority.
  - Otherwise → REQUEST. Erroring requests never touch the memory port.
- REQUEST: `o_MemRequest`=1; address/enables/data stable and registered. Timeout counter increments each cycle.
  - `i_MemAck`=1 → capture `i_MemReadData` (loads), → RESPOND.
  - Counter reaches TIMEOUT_CYCLES without ack → drop request, → RESPOND, `o_BusError`=1.
- RESPOND: `o_Done`=1 for exactly one cycle with flags/data, → IDLE.
- Byte enables: B → 0001 << addr[1:0]; H → 0011 or 1100 by addr[1]; W → 1111. Write data: byte replicated to all four lanes; half replicated to both halves; word as-is.
- Load extraction: select lane by addr[1:0]; B/H sign-extend from bit 7/15, BU/HU zero-extend, W unchanged.
- `o_LoadData`=0 on stores, on any error, and whenever `o_Done`=0.
- `i_MemAck` outside REQUEST is ignored.

## Timing

- Reset (async assert, sync release): IDLE, `o_Ready`=1, all other outputs 0, counter 0.
- Accept at edge N (`i_Valid`&`o_Ready`) → `o_MemRequest` high from cycle N+1; ack sampled at edge M → `o_Done` in cycle M+1. Minimum memory access: 2 cycles accept-to-done (ack in first request cycle).
- Error path: `o_Done` in cycle N+1, no memory request.
- Timeout: `o_MemRequest` high for exactly TIMEOUT_CYCLES cycles, `o_Done`+`o_BusError` in the following cycle; ack arriving in the same cycle as timeout expiry wins (normal completion).
- `o_Ready`=0 from N+1 through the `o_Done` cycle; new request accepted no earlier than the cycle after `o_Done`. Back-to-back throughput: one access per 3 cycles minimum.
- Reset mid-REQUEST: request dropped immediately, no `o_Done`.

## Test plan

- LB addr 0x00000103, memory word 0x80FF1234 acked first cycle → `o_MemAddress`=0x00000100, BE=0000, `o_Done` 2 cycles after accept, `o_LoadData`=0xFFFFFF80; LBU same → 0x00000080.
- SH addr 0x00000202 data 0xDEADBEEF → BE=1100, `o_MemWriteData`=0xBEEFBEEF, `o_MemWrite`=1; SB addr 0x01 data 0x5A → BE=0010, data 0x5A5A5A5A.
- LW addr 0x00000006 → `o_Done`+`o_MisalignedAccess` next cycle, `o_MemRequest` never asserts; store with mode 100 → `o_BadInstruction`=1.
- LHU addr 0x00000010, ack held off 5 cycles, word 0x0000F00D → request held 5 cycles with stable outputs, `o_LoadData`=0x0000F00D, `o_Ready` low throughout.
- No ack, TIMEOUT_CYCLES=16 → request high 16 cycles, then `o_Done`+`o_BusError`, `o_LoadData`=0; ack on cycle 16 instead → normal completion.
- `i_Reset_n` low during REQUEST → all outputs 0 asynchronously, `o_Ready`=1 after release, no `o_Done`; stray `i_MemAck` in IDLE → no effect.

Source files
------------

// File: rtl/load_store_unit.sv
// Data-memory initiator: one load/store at a time, alignment/mode checks, lane steering,
// load extension and a bounded wait for the memory acknowledge.
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        i_Clock,
    input  logic        i_Reset_n,
    input  logic        i_Valid,
    output logic        o_Ready,
    input  logic        i_Write,
    input  logic [2:0]  i_Mode,
    input  logic [31:0] i_Address,
    input  logic [31:0] i_StoreData,
    output logic        o_Done,
    output logic [31:0] o_LoadData,
    output logic        o_MisalignedAccess,
    output logic        o_BadInstruction,
    output logic        o_BusError,
    output logic        o_MemRequest,
    output logic        o_MemWrite,
    output logic [31:0] o_MemAddress,
    output logic [3:0]  o_MemByteEnable,
    output logic [31:0] o_MemWriteData,
    input  logic        i_MemAck,
    input  logic [31:0] i_MemReadData
);

    typedef enum logic [1:0] {StIdle, StRequest, StRespond} stateT;

    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYCLES - 1);

    stateT       stateQ, stateD;
    logic        writeQ, writeD;
    logic [2:0]  modeQ, modeD;
    logic [1:0]  offsetQ, offsetD;
    logic [29:0] wordAddrQ, wordAddrD;
    logic [3:0]  byteEnQ, byteEnD;
    logic [31:0] writeDataQ, writeDataD;
    logic [7:0]  countQ, countD;
    logic [31:0] loadDataQ, loadDataD;
    logic        misQ, misD;
    logic        badQ, badD;
    logic        busQ, busD;

    logic        badMode;
    logic        misaligned;
    logic [3:0]  reqByteEn;
    logic [31:0] reqWriteData;
    logic [7:0]  laneByte;
    logic [15:0] laneHalf;
    logic [31:0] extended;

    // Request decode, evaluated against the live inputs while idle
    always_comb begin
        badMode    = (i_Mode == 3'b011) || (i_Mode == 3'b110) || (i_Mode == 3'b111) ||
                     (i_Write && i_Mode[2]);
        misaligned = ((i_Mode[1:0] == 2'b01) && i_Address[0]) ||
                     ((i_Mode[1:0] == 2'b10) && (i_Address[1:0] != 2'b00));
        case (i_Mode[1:0])
            2'b00: begin
                reqByteEn    = 4'b0001 << i_Address[1:0];
                reqWriteData = {4{i_StoreData[7:0]}};
            end
            2'b01: begin
                reqByteEn    = i_Address[1] ? 4'b1100 : 4'b0011;
                reqWriteData = {2{i_StoreData[15:0]}};
            end
            default: begin
                reqByteEn    = 4'b1111;
                reqWriteData = i_StoreData;
            end
        endcase
        if (!i_Write) begin
            reqByteEn    = 4'b0000;
            reqWriteData = 32'h0;
        end
    end

    // Lane select and extension of the returned read word
    always_comb begin
        unique case (offsetQ)
            2'd0:    laneByte = i_MemReadData[7:0];
            2'd1:    laneByte = i_MemReadData[15:8];
            2'd2:    laneByte = i_MemReadData[23:16];
            default: laneByte = i_MemReadData[31:24];
        endcase
        laneHalf = offsetQ[1] ? i_MemReadData[31:16] : i_MemReadData[15:0];
        case (modeQ)
            3'b000:  extended = {{24{laneByte[7]}}, laneByte};
            3'b001:  extended = {{16{laneHalf[15]}}, laneHalf};
            3'b100:  extended = {24'h0, laneByte};
            3'b101:  extended = {16'h0, laneHalf};
            default: extended = i_MemReadData;
        endcase
    end

    always_comb begin
        stateD     = stateQ;
        writeD     = writeQ;
        modeD      = modeQ;
        offsetD    = offsetQ;
        wordAddrD  = wordAddrQ;
        byteEnD    = byteEnQ;
        writeDataD = writeDataQ;
        countD     = countQ;
        loadDataD  = loadDataQ;
        misD       = misQ;
        badD       = badQ;
        busD       = busQ;
        case (stateQ)
            StIdle: begin
                if (i_Valid) begin
                    writeD     = i_Write;
                    modeD      = i_Mode;
                    offsetD    = i_Address[1:0];
                    wordAddrD  = i_Address[31:2];
                    byteEnD    = reqByteEn;
                    writeDataD = reqWriteData;
                    countD     = 8'd0;
                    loadDataD  = 32'h0;
                    misD       = 1'b0;
                    badD       = 1'b0;
                    busD       = 1'b0;
                    if (badMode) begin
                        badD   = 1'b1;
                        stateD = StRespond;
                    end else if (misaligned) begin
                        misD   = 1'b1;
                        stateD = StRespond;
                    end else begin
                        stateD = StRequest;
                    end
                end
            end
            StRequest: begin
                countD = countQ + 8'd1;
                // An ack in the expiry cycle still completes normally
                if (i_MemAck) begin
                    loadDataD = writeQ ? 32'h0 : extended;
                    stateD    = StRespond;
                end else if (countQ == TimeoutLast) begin
                    busD   = 1'b1;
                    stateD = StRespond;
                end
            end
            StRespond: begin
                countD    = 8'd0;
                loadDataD = 32'h0;
                misD      = 1'b0;
                badD      = 1'b0;
                busD      = 1'b0;
                stateD    = StIdle;
            end
            default: stateD = StIdle;
        endcase
    end

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            stateQ     <= StIdle;
            writeQ     <= 1'b0;
            modeQ      <= 3'b000;
            offsetQ    <= 2'b00;
            wordAddrQ  <= 30'h0;
            byteEnQ    <= 4'b0000;
            writeDataQ <= 32'h0;
            countQ     <= 8'd0;
            loadDataQ  <= 32'h0;
            misQ       <= 1'b0;
            badQ       <= 1'b0;
            busQ       <= 1'b0;
        end else begin
            stateQ     <= stateD;
            writeQ     <= writeD;
            modeQ      <= modeD;
            offsetQ    <= offsetD;
            wordAddrQ  <= wordAddrD;
            byteEnQ    <= byteEnD;
            writeDataQ <= writeDataD;
            countQ     <= countD;
            loadDataQ  <= loadDataD;
            misQ       <= misD;
            badQ       <= badD;
            busQ       <= busD;
        end
    end

    // Port outputs are registered values qualified by the state register
    always_comb begin
        o_Ready            = (stateQ == StIdle);
        o_MemRequest       = (stateQ == StRequest);
        o_Done             = (stateQ == StRespond);
        o_MemWrite         = o_MemRequest && writeQ;
        o_MemAddress       = o_MemRequest ? {wordAddrQ, 2'b00} : 32'h0;
        o_MemByteEnable    = o_MemRequest ? byteEnQ : 4'b0000;
        o_MemWriteData     = o_MemRequest ? writeDataQ : 32'h0;
        o_LoadData         = o_Done ? loadDataQ : 32'h0;
        o_MisalignedAccess = o_Done && misQ;
        o_BadInstruction   = o_Done && badQ;
        o_BusError         = o_Done && busQ;
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed accesses push expected completions,
// a negedge monitor pops and compares on every o_Done.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rstN;
    logic        valid;
    logic        ready;
    logic        write;
    logic [2:0]  mode;
    logic [31:0] addr;
    logic [31:0] storeData;
    logic        done;
    logic [31:0] loadData;
    logic        misaligned;
    logic        badInstr;
    logic        busError;
    logic        memReq;
    logic        memWrite;
    logic [31:0] memAddr;
    logic [3:0]  memBe;
    logic [31:0] memWdata;
    logic        memAck;
    logic [31:0] memRdata;

    int tests = 0;
    int fails = 0;
    logic [34:0] expQ[$];
    logic [34:0] expItem;

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT_CYCLES(16)) dut (
        .i_Clock(clk), .i_Reset_n(rstN), .i_Valid(valid), .o_Ready(ready),
        .i_Write(write), .i_Mode(mode), .i_Address(addr), .i_StoreData(storeData),
        .o_Done(done), .o_LoadData(loadData), .o_MisalignedAccess(misaligned),
        .o_BadInstruction(badInstr), .o_BusError(busError), .o_MemRequest(memReq),
        .o_MemWrite(memWrite), .o_MemAddress(memAddr), .o_MemByteEnable(memBe),
        .o_MemWriteData(memWdata), .i_MemAck(memAck), .i_MemReadData(memRdata)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every completion must match the oldest expected response
    always @(negedge clk) begin
        if (rstN === 1'b1) begin
            if (done === 1'b1) begin
                if (expQ.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_done: got o_Done=1 expected no completion");
                end else begin
                    expItem = expQ.pop_front();
                    check("done_loaddata", loadData, expItem[34:3]);
                    check("done_misaligned", {31'h0, misaligned}, {31'h0, expItem[2]});
                    check("done_badinstr", {31'h0, badInstr}, {31'h0, expItem[1]});
                    check("done_buserror", {31'h0, busError}, {31'h0, expItem[0]});
                end
            end else begin
                check("idle_loaddata_zero", loadData, 32'h0);
            end
        end
    end

    // ackDelay: index of the request cycle carrying the ack (-1 = never ack)
    task automatic access(input logic wr, input logic [2:0] md, input logic [31:0] a,
                          input logic [31:0] sd, input int ackDelay, input logic [31:0] rd,
                          input logic [31:0] expAddr, input logic [3:0] expBe,
                          input logic [31:0] expWd, input int expCycles,
                          input logic [31:0] expLoad, input logic expMis, input logic expBad,
                          input logic expBus);
        int cycles;
        @(negedge clk);
        check("ready_before_accept", {31'h0, ready}, 32'h1);
        valid = 1'b1;
        write = wr;
        mode = md;
        addr = a;
        storeData = sd;
        expQ.push_back({expLoad, expMis, expBad, expBus});
        @(negedge clk);
        valid = 1'b0;
        check("ready_after_accept", {31'h0, ready}, 32'h0);
        cycles = 0;
        while (memReq === 1'b1 && cycles < 300) begin
            check("mem_address", memAddr, expAddr);
            check("mem_byteenable", {28'h0, memBe}, {28'h0, expBe});
            check("mem_write", {31'h0, memWrite}, {31'h0, wr});
            if (wr) check("mem_writedata", memWdata, expWd);
            check("ready_during_request", {31'h0, ready}, 32'h0);
            if (cycles == ackDelay) begin
                memAck = 1'b1;
                memRdata = rd;
            end
            cycles++;
            @(negedge clk);
            memAck = 1'b0;
            memRdata = 32'hA5A5_A5A5;
        end
        check("request_cycles", cycles, expCycles);
        check("done_pulse", {31'h0, done}, 32'h1);
        check("ready_in_done", {31'h0, ready}, 32'h0);
        @(negedge clk);
        check("done_single_cycle", {31'h0, done}, 32'h0);
        check("ready_after_done", {31'h0, ready}, 32'h1);
    endtask

    initial begin
        rstN = 1'b1;
        valid = 1'b0;
        write = 1'b0;
        mode = 3'b000;
        addr = 32'h0;
        storeData = 32'h0;
        memAck = 1'b0;
        memRdata = 32'h0;
        #1 rstN = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("reset_ready", {31'h0, ready}, 32'h1);
        check("reset_memreq", {31'h0, memReq}, 32'h0);
        check("reset_done", {31'h0, done}, 32'h0);
        check("reset_memaddr", memAddr, 32'h0);
        rstN = 1'b1;

        // wr mode addr sdata ackDelay rdata | memAddr be wdata cycles load mis bad bus
        access(1'b0, 3'b000, 32'h0000_0103, 32'h0, 0, 32'h80FF_1234,
               32'h0000_0100, 4'b0000, 32'h0, 1, 32'hFFFF_FF80, 1'b0, 1'b0, 1'b0);
        access(1'b0, 3'b100, 32'h0000_0103, 32'h0, 0, 32'h80FF_1234,
               32'h0000_0100, 4'b0000, 32'h0, 1, 32'h0000_0080, 1'b0, 1'b0, 1'b0);
        access(1'b1, 3'b001, 32'h0000_0202, 32'hDEAD_BEEF, 0, 32'h0,
               32'h0000_0200, 4'b1100, 32'hBEEF_BEEF, 1, 32'h0, 1'b0, 1'b0, 1'b0);
        access(1'b1, 3'b000, 32'h0000_0001, 32'h0000_005A, 0, 32'h0,
               32'h0000_0000, 4'b0010, 32'h5A5A_5A5A, 1, 32'h0, 1'b0, 1'b0, 1'b0);
        access(1'b1, 3'b010, 32'h0000_0030, 32'h1122_3344, 2, 32'h0,
               32'h0000_0030, 4'b1111, 32'h1122_3344, 3, 32'h0, 1'b0, 1'b0, 1'b0);
        access(1'b0, 3'b010, 32'h0000_0006, 32'h0, 0, 32'h0,
               32'h0, 4'b0000, 32'h0, 0, 32'h0, 1'b1, 1'b0, 1'b0);
        access(1'b1, 3'b100, 32'h0000_0000, 32'h1234_5678, 0, 32'h0,
               32'h0, 4'b0000, 32'h0, 0, 32'h0, 1'b0, 1'b1, 1'b0);
        // illegal mode wins over misalignment
        access(1'b0, 3'b011, 32'h0000_0001, 32'h0, 0, 32'h0,
               32'h0, 4'b0000, 32'h0, 0, 32'h0, 1'b0, 1'b1, 1'b0);
        access(1'b0, 3'b101, 32'h0000_0010, 32'h0, 4, 32'h0000_F00D,
               32'h0000_0010, 4'b0000, 32'h0, 5, 32'h0000_F00D, 1'b0, 1'b0, 1'b0);
        access(1'b0, 3'b001, 32'h0000_0012, 32'h0, 1, 32'h8001_0000,
               32'h0000_0010, 4'b0000, 32'h0, 2, 32'hFFFF_8001, 1'b0, 1'b0, 1'b0);
        access(1'b0, 3'b010, 32'h0000_0020, 32'h0, 0, 32'h1234_5678,
               32'h0000_0020, 4'b0000, 32'h0, 1, 32'h1234_5678, 1'b0, 1'b0, 1'b0);
        access(1'b0, 3'b010, 32'h0000_0040, 32'h0, -1, 32'h0,
               32'h0000_0040, 4'b0000, 32'h0, 16, 32'h0, 1'b0, 1'b0, 1'b1);
        access(1'b0, 3'b010, 32'h0000_0044, 32'h0, 15, 32'hCAFE_F00D,
               32'h0000_0044, 4'b0000, 32'h0, 16, 32'hCAFE_F00D, 1'b0, 1'b0, 1'b0);

        // Reset while a request is outstanding: no completion afterwards
        @(negedge clk);
        valid = 1'b1;
        write = 1'b0;
        mode = 3'b010;
        addr = 32'h0000_0050;
        @(negedge clk);
        valid = 1'b0;
        @(negedge clk);
        check("pre_reset_memreq", {31'h0, memReq}, 32'h1);
        #2 rstN = 1'b0;
        #1;
        check("async_reset_memreq", {31'h0, memReq}, 32'h0);
        check("async_reset_memaddr", memAddr, 32'h0);
        check("async_reset_done", {31'h0, done}, 32'h0);
        @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);
        check("post_reset_ready", {31'h0, ready}, 32'h1);
        check("post_reset_done", {31'h0, done}, 32'h0);

        // Stray ack while idle is ignored
        memAck = 1'b1;
        memRdata = 32'hFFFF_FFFF;
        @(negedge clk);
        memAck = 1'b0;
        check("stray_ack_done", {31'h0, done}, 32'h0);
        check("stray_ack_memreq", {31'h0, memReq}, 32'h0);
        check("stray_ack_ready", {31'h0, ready}, 32'h1);
        access(1'b0, 3'b000, 32'h0000_0060, 32'h0, 0, 32'h0000_007F,
               32'h0000_0060, 4'b0000, 32'h0, 1, 32'h0000_007F, 1'b0, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", expQ.size(), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
